uart_frame_decoder: RTL and testbench

//   Byte-stream framer between the RX FIFO read side and the command/inference logic.

---
 rtl/uart_frame_pkg.sv | 29 ++
 rtl/uart_frame_timeout.sv | 54 +++++
 rtl/uart_frame_decoder.sv | 219 +++++++++++++++++++++
 tb/tb_uart_frame_decoder.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame decoder.
//   state_t : decoder FSM states
//   err_t   : error codes reported on err_code
//   SOF_DEFAULT : default start-of-frame marker
//   sat_inc : saturating 16-bit increment used by the status counters
package uart_frame_pkg;

    typedef enum logic [2:0] {
        HUNT,
        LEN,
        PAYLOAD,
        CKSUM,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_LEN,
        ERR_CKSUM,
        ERR_TIMEOUT
    } err_t;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte timeout counter for the UART frame decoder.
// Counts enabled, non-held cycles and pulses 'expired' on the cycle the count
// reaches TIMEOUT_CYCLES-1.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous reset, active-high
//   enable     in   counting allowed (decoder is inside a frame)
//   clear      in   restart from zero (byte accepted or outside a frame)
//   hold       in   freeze the count (downstream back-pressure)
//   load       in   load load_value into the counter
//   load_value in   value used by load
//   expired    out  one-cycle expiry pulse
module uart_frame_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 500_000,
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic             hold,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             expired
);

    localparam logic [CNT_W-1:0] Limit = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired = enable && !clear && !load && !hold && (cnt_q == Limit);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_value;
        end else if (expired) begin
            cnt_d = '0;
        end else if (enable && !hold) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_frame_decoder.sv
// Byte-stream framer between the RX FIFO read side and the command logic.
// Hunts for SOF, reads LEN, forwards LEN payload bytes on a valid/ready stream
// with m_last, and reports one status pulse per frame. An inter-byte timeout
// aborts stalled frames.
// Build option: define UART_FRAME_CKSUM_EN to expect a trailing checksum byte
// equal to (LEN + sum of payload) mod 256.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   s_data/s_valid/s_ready byte input from the RX FIFO (s_ready is the FIFO r_en)
//   m_data/m_valid/m_ready/m_last  payload output stream
//   frame_ok / frame_err  one-cycle status pulses
//   err_code              code of the most recent error
//   frame_cnt / err_cnt   saturating good/bad frame counters
module uart_frame_decoder
    import uart_frame_pkg::*;
#(
    parameter int unsigned CLK_FREQ       = 50_000_000,
    parameter logic [7:0]  SOF_BYTE       = SOF_DEFAULT,
    parameter int unsigned MAX_LEN        = 64,
    parameter int unsigned TIMEOUT_CYCLES = CLK_FREQ / 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
);

    localparam logic [7:0] MaxLenB = 8'(MAX_LEN);

`ifdef UART_FRAME_CKSUM_EN
    localparam state_t AfterPayload = CKSUM;
`else
    localparam state_t AfterPayload = DONE;
`endif

    state_t      state_q, state_d;
    logic        accept;
    logic        timed_state;
    logic        stall;
    logic        tmo_expired;
    logic        len_bad;
    logic        err_evt;
    err_t        err_kind;

    logic [7:0]  remaining_q;
    logic [7:0]  sum_q;
    logic        m_valid_q;
    logic        m_last_q;
    logic [7:0]  m_data_q;
    logic        frame_err_q;
    err_t        err_code_q;
    logic [15:0] frame_cnt_q;
    logic [15:0] err_cnt_q;

    assign accept      = s_valid && s_ready;
    assign timed_state = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CKSUM);
    assign stall       = m_valid_q && !m_ready;
    assign len_bad     = (s_data == 8'd0) || (s_data > MaxLenB);

    uart_frame_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk        (clk),
        .rst        (rst),
        .enable     (timed_state),
        .clear      (accept || !timed_state),
        .hold       (stall),
        .load       (1'b0),
        .load_value ('0),
        .expired    (tmo_expired)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; err_evt/err_kind flag an abort or rejection this cycle
    always_comb begin
        state_d  = state_q;
        err_evt  = 1'b0;
        err_kind = ERR_NONE;
        case (state_q)
            HUNT: begin
                if (accept && (s_data == SOF_BYTE)) begin
                    state_d = LEN;
                end
            end
            LEN: begin
                if (accept) begin
                    if (len_bad) begin
                        err_evt  = 1'b1;
                        err_kind = ERR_LEN;
                        state_d  = HUNT;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end else if (tmo_expired) begin
                    err_evt  = 1'b1;
                    err_kind = ERR_TIMEOUT;
                    state_d  = HUNT;
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    if (remaining_q == 8'd1) begin
                        state_d = AfterPayload;
                    end
                end else if (tmo_expired) begin
                    err_evt  = 1'b1;
                    err_kind = ERR_TIMEOUT;
                    state_d  = HUNT;
                end
            end
`ifdef UART_FRAME_CKSUM_EN
            CKSUM: begin
                if (accept) begin
                    if (s_data == sum_q) begin
                        state_d = DONE;
                    end else begin
                        err_evt  = 1'b1;
                        err_kind = ERR_CKSUM;
                        state_d  = HUNT;
                    end
                end else if (tmo_expired) begin
                    err_evt  = 1'b1;
                    err_kind = ERR_TIMEOUT;
                    state_d  = HUNT;
                end
            end
`endif
            DONE: begin
                state_d = HUNT;
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        s_ready  = 1'b0;
        frame_ok = 1'b0;
        case (state_q)
            HUNT, LEN, CKSUM: s_ready = 1'b1;
            PAYLOAD:          s_ready = !m_valid_q || m_ready;
            DONE:             frame_ok = 1'b1;
            default:          s_ready = 1'b0;
        endcase
    end

    // Frame datapath, output register and status
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining_q <= 8'd0;
            sum_q       <= 8'd0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_data_q    <= 8'd0;
            frame_err_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            frame_cnt_q <= 16'd0;
            err_cnt_q   <= 16'd0;
        end else begin
            if ((state_q == LEN) && accept) begin
                remaining_q <= s_data;
                sum_q       <= s_data;
            end

            // Output register: a pending byte survives an abort and is still delivered
            if ((state_q == PAYLOAD) && accept) begin
                remaining_q <= remaining_q - 8'd1;
                sum_q       <= sum_q + s_data;
                m_valid_q   <= 1'b1;
                m_data_q    <= s_data;
                m_last_q    <= (remaining_q == 8'd1);
            end else if (m_ready) begin
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
            end

            frame_err_q <= err_evt;
            if (err_evt) begin
                err_code_q <= err_kind;
            end

            if (frame_ok) begin
                frame_cnt_q <= sat_inc(frame_cnt_q);
            end
            if (frame_err_q) begin
                err_cnt_q <= sat_inc(err_cnt_q);
            end
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_last    = m_last_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;
    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Self-checking bench for uart_frame_decoder. Directed scenarios plus a
// randomized frame stream, checked against a byte-stream parsing model.
module tb_uart_frame_decoder;

    localparam int unsigned TO   = 40;
    localparam int unsigned MAXL = 64;
    localparam logic [7:0]  SOF  = 8'hA5;
`ifdef UART_FRAME_CKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    typedef logic [7:0] bq_t[$];

    logic        clk;
    logic        rst;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic        frame_ok;
    logic        frame_err;
    logic [1:0]  err_code;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;

    int checks = 0;
    int failures = 0;
    int exp_data[$];
    int got_data[$];
    int exp_stat[$];
    int got_stat[$];
    int exp_ok = 0;
    int exp_err = 0;
    int mode = 0;
    int mvalid_cycles = 0;
    logic       prev_stall = 1'b0;
    logic [8:0] prev_word = 9'd0;

    uart_frame_decoder #(
        .CLK_FREQ      (50_000_000),
        .SOF_BYTE      (8'hA5),
        .MAX_LEN       (MAXL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Downstream ready: 0 = always ready, 1 = random, 2 = pattern 1-0-0-1
    initial begin
        int ph;
        ph = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                1: m_ready = 1'($urandom_range(0, 1));
                2: begin
                    m_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
                    ph++;
                end
                default: m_ready = 1'b1;
            endcase
        end
    end

    // Monitor: records transfers and status pulses, checks hold and exclusivity
    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid && m_ready) got_data.push_back(int'({m_last, m_data}));
            if (frame_ok) got_stat.push_back(4);
            if (frame_err) got_stat.push_back(int'(err_code));
            if (frame_ok || frame_err)
                check("ok_err_exclusive", 32'(frame_ok && frame_err), 32'd0);
            if (prev_stall) begin
                check("hold_valid", 32'(m_valid), 32'd1);
                check("hold_word", 32'({m_last, m_data}), 32'(prev_word));
            end
            if (m_valid) mvalid_cycles <= mvalid_cycles + 1;
        end
        prev_stall <= m_valid && !m_ready && !rst;
        prev_word  <= {m_last, m_data};
    end

    function automatic void add_ok();
        exp_stat.push_back(4);
        exp_ok++;
    endfunction

    function automatic void add_err(input int code);
        exp_stat.push_back(code);
        exp_err++;
    endfunction

    // Reference: parse a byte stream by index; timed_out means the line went idle after it
    function automatic void model(input bq_t s, input bit timed_out);
        int i;
        logic [7:0] len;
        logic [7:0] sum;
        logic lst;
        i = 0;
        while (i < s.size()) begin
            if (s[i] != SOF) begin
                i++;
                continue;
            end
            i++;
            if (i >= s.size()) begin
                if (timed_out) add_err(3);
                return;
            end
            len = s[i];
            i++;
            if (len == 8'd0 || int'(len) > int'(MAXL)) begin
                add_err(1);
                continue;
            end
            sum = len;
            for (int k = 0; k < int'(len); k++) begin
                if (i >= s.size()) begin
                    if (timed_out) add_err(3);
                    return;
                end
                lst = (k == int'(len) - 1);
                exp_data.push_back(int'({lst, s[i]}));
                sum = sum + s[i];
                i++;
            end
            if (CK) begin
                if (i >= s.size()) begin
                    if (timed_out) add_err(3);
                    return;
                end
                if (s[i] == sum) add_ok();
                else add_err(2);
                i++;
            end else begin
                add_ok();
            end
        end
    endfunction

    task automatic put(input logic [7:0] b, input int unsigned max_gap);
        bit ok;
        int n;
        int unsigned gap;
        s_valid = 1'b0;
        gap = $urandom_range(0, max_gap);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        s_data  = b;
        s_valid = 1'b1;
        ok = 1'b0;
        n = 0;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #1;
            n++;
        end
        s_valid = 1'b0;
        check("s_accept", 32'(ok), 32'd1);
    endtask

    task automatic send(input bq_t s, input int unsigned max_gap);
        foreach (s[i]) put(s[i], max_gap);
    endtask

    task automatic drain();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_valid && n < 200);
        check("drain", 32'(m_valid), 32'd0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic compare(input string tag);
        check({tag, "_ndata"}, 32'(got_data.size()), 32'(exp_data.size()));
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++)
            check({tag, "_data"}, 32'(got_data[i]), 32'(exp_data[i]));
        check({tag, "_nstat"}, 32'(got_stat.size()), 32'(exp_stat.size()));
        for (int i = 0; i < got_stat.size() && i < exp_stat.size(); i++)
            check({tag, "_stat"}, 32'(got_stat[i]), 32'(exp_stat[i]));
        check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_ok));
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
        got_data.delete();
        exp_data.delete();
        got_stat.delete();
        exp_stat.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        check({tag, "_m_data"}, 32'(m_data), 32'd0);
        check({tag, "_m_last"}, 32'(m_last), 32'd0);
        check({tag, "_frame_ok"}, 32'(frame_ok), 32'd0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        check({tag, "_err_code"}, 32'(err_code), 32'd0);
        check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    endtask

    initial begin
        bq_t q;
        bq_t good;
        int mv0;
        logic [7:0] len;
        logic [7:0] sum;
        logic [7:0] b;
        int unsigned r;

        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'd0;
        good    = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Good frame with latency check on the first payload byte
        put(8'hA5, 0);
        put(8'h03, 0);
        put(8'h11, 0);
        @(negedge clk);
        check("latency_valid", 32'(m_valid), 32'd1);
        check("latency_data", 32'(m_data), 32'h11);
        @(posedge clk);
        #1;
        put(8'h22, 0);
        put(8'h33, 0);
        put(8'h69, 0);
        drain();
        model(good, 1'b0);
        compare("good");

        // Checksum-error stream (plain frame plus junk when checksum is off)
        q = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
        send(q, 1);
        drain();
        model(q, 1'b0);
        compare("cksum");

        // Bad lengths never produce output, then a good frame decodes
        mv0 = mvalid_cycles;
        q = '{8'hA5, 8'h00, 8'hA5, 8'h41};
        send(q, 1);
        drain();
        check("badlen_no_valid", 32'(mvalid_cycles - mv0), 32'd0);
        model(q, 1'b0);
        send(good, 1);
        drain();
        model(good, 1'b0);
        compare("badlen");

        // Back-pressure with ready pattern 1-0-0-1
        mode = 2;
        q = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04};
        if (CK) q.push_back(8'h0E);
        send(q, 0);
        drain();
        mode = 0;
        model(q, 1'b0);
        compare("bp");

        // Timeout mid-payload, then resync through leading junk
        q = '{8'hA5, 8'h05, 8'hAA};
        send(q, 0);
        repeat (TO + 10) @(posedge clk);
        #1;
        model(q, 1'b1);
        q = '{8'h00, 8'hFF, 8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        send(q, 1);
        drain();
        model(q, 1'b0);
        compare("timeout");

        // Reset after two payload bytes
        q = '{8'hA5, 8'h05, 8'h31, 8'h32};
        send(q, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_zero("midreset");
        got_data.delete();
        exp_data.delete();
        got_stat.delete();
        exp_stat.delete();
        exp_ok  = 0;
        exp_err = 0;
        @(posedge clk);
        #1;
        send(good, 1);
        drain();
        model(good, 1'b0);
        compare("after_reset");

        // Randomized frame stream with random downstream ready
        q.delete();
        for (int f = 0; f < 25; f++) begin
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom_range(0, 255));
                if (b == SOF) b = 8'h00;
                q.push_back(b);
            end
            q.push_back(SOF);
            r = $urandom_range(0, 9);
            if (r == 0) begin
                q.push_back(8'h00);
                continue;
            end
            if (r == 1) begin
                q.push_back(8'($urandom_range(65, 255)));
                continue;
            end
            len = 8'($urandom_range(1, 12));
            q.push_back(len);
            sum = len;
            for (int k = 0; k < int'(len); k++) begin
                b = ($urandom_range(0, 5) == 0) ? SOF : 8'($urandom_range(0, 255));
                q.push_back(b);
                sum = sum + b;
            end
            if (CK) q.push_back((r == 2) ? (sum ^ 8'h5A) : sum);
        end
        mode = 1;
        send(q, 2);
        drain();
        mode = 0;
        model(q, 1'b0);
        compare("random");

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: time limit reached before end of run");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
